interrupt_request_controller: RTL and testbench
===============================================

// Module: interrupt_request_controller
// PURPOSE
//  Initiator side of the processor interrupt interface. It collects external
//  IRQ lines, latches rising edges as pending requests and applies a
//  software mask. It issues a one-cycle 'interrupt' pulse to the jump control
//  logic, which saves the PC and flags and vectors to 8'hF0. It then holds off
//  further interrupts until the ISR's RET (opcode 5'b10000) is seen in the
//  decode stage. Sits beside the jump control block and the register file.
// PARAMETERS
//  NUM_IRQ    4        number of request lines; 1..8
//  ID_W       2        width of int_id; must be >= clog2(NUM_IRQ)
// PORTS
//  clk          in   1        system clock, rising edge
//  reset        in   1        asynchronous, active-low; 0 clears all state
//  irq_in       in   NUM_IRQ  request lines, synchronous to clk, level
//  mask_we      in   1        write enable for mask register
//  mask_wdata   in   NUM_IRQ  new mask; bit=1 blocks that line
//  ins          in   20       instruction in decode stage (RET = ins[19:15]==5'b10000)
//  pc_mux_sel   in   1        control transfer being taken this cycle
//  interrupt    out  1        one-cycle request pulse to jump control
//  int_id       out  ID_W     index of the line being/last serviced
//  in_service   out  1        1 from pulse until RET retires the ISR
//  pending      out  NUM_IRQ  pending request bits
//  irq_mask     out  NUM_IRQ  current mask register
// BEHAVIOUR
//  Reset (reset=0, async):
//   - interrupt=0, int_id=0, in_service=0, pending=0, irq_mask=all 1s,
//     irq_prev=0, state=IDLE.
//  Edge detect:
//   - irq_prev <= irq_in each cycle; rise = irq_in & ~irq_prev.
//   - A rise sets pending[i] regardless of mask or state.
//   - A level held high raises only one request.
//  Mask:
//   - mask_we=1 loads irq_mask at the clock edge.
//   - The new mask is used from the next cycle.
//   - Masked pending bits are retained, not dropped.
//  Eligible set: elig = pending & ~irq_mask.
//   - Priority: lowest index wins.
//  FSM (IDLE, FIRE, SERVICE):
//   - IDLE -> FIRE when |elig and pc_mux_sel==0 and no RET in ins.
//     On that edge:
//       - int_id <= winner index
//       - pending[winner] cleared
//       - interrupt <= 1
//   - pc_mux_sel=1 defers the request, so the PC captured by jump control is
//     never a mid-transfer address.
//   - FIRE -> SERVICE unconditionally. interrupt <= 0 and in_service <= 1.
//     interrupt is high for exactly one cycle, with latency 1 clk from the
//     qualifying edge.
//   - SERVICE -> IDLE on an edge where the RET decode is true; in_service <= 0.
//     The earliest re-fire is then 1 cycle later. No nesting.
//   - RET seen in IDLE or FIRE is ignored.
//  Simultaneous events:
//   - A rise on the winner line in the same cycle as its ack leaves
//     pending[winner]=1 (set wins over clear).
//   - mask_we and a fire decision in the same cycle: the decision uses the
//     old mask.
//  Mid-operation:
//   - Reset asserted in any state returns to IDLE at once and drops pending.
//   - irq_in changes while in FIRE/SERVICE are only latched into pending.
//  Widths: int_id zero-extended when NUM_IRQ < 2**ID_W.
// TESTING
//  T1 reset=0 then 1, irq_mask=4'b0000, pulse irq_in[2] one cycle ->
//     interrupt high exactly 1 cycle, 2 clks after the rise; int_id=2;
//     pending=0; in_service=1.
//  T2 irq_in=4'b1010 rise together, mask 0 -> first fire int_id=1,
//     pending=4'b1000. Drive RET (ins=20'h80000) -> 1 clk later fire with
//     int_id=3.
//  T3 irq_mask=4'b0001, rise irq_in[0] -> no interrupt, pending=4'b0001.
//     Write mask 0 -> interrupt the cycle after the write takes effect.
//  T4 request eligible while pc_mux_sel=1 for 3 cycles -> interrupt held
//     off; fires 1 clk after pc_mux_sel falls.
//  T5 irq_in[1] held high 20 cycles -> exactly one pending set and one
//     interrupt. Rise again during the ack cycle -> pending[1] remains 1.
//  T6 reset=0 asynchronously while in SERVICE with pending=4'b0100 ->
//     outputs at reset values before the next clk edge. After release, no
//     interrupt without a new rise.

Source files
------------

// File: rtl/interrupt_request_controller.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_request_controller
// Description : Initiator side of the processor interrupt interface. External
//               IRQ lines are edge-detected into pending bits and filtered by
//               a software mask. The lowest-index eligible line wins. The block
//               sends a one-cycle 'interrupt' pulse to jump control and then
//               blocks further interrupts until RET is decoded.
// Ports       : clk        - system clock, rising edge
//               reset      - asynchronous, active-low; clears all state
//               irq_in     - request lines (level, synchronous to clk)
//               mask_we    - mask register write enable
//               mask_wdata - new mask value (1 blocks the line)
//               ins        - decode-stage instruction (RET: ins[19:15]=10000)
//               pc_mux_sel - control transfer taken this cycle
//               interrupt  - one-cycle request pulse to jump control
//               int_id     - index of the line being / last serviced
//               in_service - high from the pulse until RET retires the ISR
//               pending    - latched request bits
//               irq_mask   - current mask register
// Revision    : 1.0 - initial release
// ============================================================================
module interrupt_request_controller #(
   parameter int NUM_IRQ = 4,
   parameter int ID_W    = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic               mask_we,
   input  logic [NUM_IRQ-1:0] mask_wdata,
   input  logic [19:0]        ins,
   input  logic               pc_mux_sel,
   output logic               interrupt,
   output logic [ID_W-1:0]    int_id,
   output logic               in_service,
   output logic [NUM_IRQ-1:0] pending,
   output logic [NUM_IRQ-1:0] irq_mask
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_FIRE    = 2'd1;
   localparam logic [1:0] S_SERVICE = 2'd2;

   localparam logic [4:0] RET_OPCODE = 5'b10000;

   logic [1:0]         state_q,      state_d;
   logic [NUM_IRQ-1:0] irq_prev_q;
   logic [NUM_IRQ-1:0] pending_q,    pending_d;
   logic [NUM_IRQ-1:0] irq_mask_q,   irq_mask_d;
   logic [ID_W-1:0]    int_id_q,     int_id_d;
   logic               interrupt_q,  interrupt_d;
   logic               in_service_q, in_service_d;

   logic [NUM_IRQ-1:0] rise;
   logic [NUM_IRQ-1:0] elig;
   logic [NUM_IRQ-1:0] winner_oh;
   logic [ID_W-1:0]    winner_id;
   logic               ret_seen;
   logic               fire;
   logic               ins_unused;

   // Only the opcode field of the decode-stage instruction matters here.
   assign ins_unused = ^ins[14:0];

   assign rise     = irq_in & ~irq_prev_q;
   assign elig     = pending_q & ~irq_mask_q;
   assign ret_seen = (ins[19:15] == RET_OPCODE);

   // Walk from the top index down so the lowest set index is what remains.
   always_comb begin
      winner_id = '0;
      winner_oh = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (elig[i]) begin
            winner_id    = ID_W'(i);
            winner_oh    = '0;
            winner_oh[i] = 1'b1;
         end
      end
   end

   // A taken control transfer or a RET in decode defers the request so jump
   // control never captures a mid-transfer PC.
   assign fire = (state_q == S_IDLE) && (|elig) && !pc_mux_sel && !ret_seen;

   always_comb begin
      state_d      = state_q;
      int_id_d     = int_id_q;
      interrupt_d  = interrupt_q;
      in_service_d = in_service_q;
      irq_mask_d   = mask_we ? mask_wdata : irq_mask_q;

      // A rise on the winner in its ack cycle must survive, so set wins.
      pending_d = (pending_q & ~(fire ? winner_oh : '0)) | rise;

      case (state_q)
         S_IDLE: begin
            if (fire) begin
               state_d     = S_FIRE;
               int_id_d    = winner_id;
               interrupt_d = 1'b1;
            end
         end
         S_FIRE: begin
            state_d      = S_SERVICE;
            interrupt_d  = 1'b0;
            in_service_d = 1'b1;
         end
         S_SERVICE: begin
            if (ret_seen) begin
               state_d      = S_IDLE;
               in_service_d = 1'b0;
            end
         end
         default: begin
            state_d      = S_IDLE;
            interrupt_d  = 1'b0;
            in_service_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         irq_prev_q   <= '0;
         pending_q    <= '0;
         irq_mask_q   <= '1;
         int_id_q     <= '0;
         interrupt_q  <= 1'b0;
         in_service_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         irq_prev_q   <= irq_in;
         pending_q    <= pending_d;
         irq_mask_q   <= irq_mask_d;
         int_id_q     <= int_id_d;
         interrupt_q  <= interrupt_d;
         in_service_q <= in_service_d;
      end
   end

   assign interrupt  = interrupt_q;
   assign int_id     = int_id_q;
   assign in_service = in_service_q;
   assign pending    = pending_q;
   assign irq_mask   = irq_mask_q;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_request_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_interrupt_request_controller
// Description : Scoreboard bench for interrupt_request_controller. A reference
//               model queues the expected interrupt pulses. A monitor
//               compares DUT pulses and status outputs on each falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interrupt_request_controller;

   localparam int NUM_IRQ = 4;
   localparam int ID_W    = 2;
   localparam logic [19:0] RET = 20'h80000;

   logic               clk        = 1'b0;
   logic               reset      = 1'b1;
   logic [NUM_IRQ-1:0] irq_in     = '0;
   logic               mask_we    = 1'b0;
   logic [NUM_IRQ-1:0] mask_wdata = '0;
   logic [19:0]        ins        = '0;
   logic               pc_mux_sel = 1'b0;
   logic               interrupt;
   logic [ID_W-1:0]    int_id;
   logic               in_service;
   logic [NUM_IRQ-1:0] pending;
   logic [NUM_IRQ-1:0] irq_mask;

   always #5 clk = ~clk;

   interrupt_request_controller #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .irq_in     (irq_in),
      .mask_we    (mask_we),
      .mask_wdata (mask_wdata),
      .ins        (ins),
      .pc_mux_sel (pc_mux_sel),
      .interrupt  (interrupt),
      .int_id     (int_id),
      .in_service (in_service),
      .pending    (pending),
      .irq_mask   (irq_mask)
   );

   typedef struct {
      int cyc;
      int id;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_vec  = 0;
   int   n_bad  = 0;
   int   cyc    = 0;
   bit   chk_en = 1'b0;

   // Reference model state: the request lines seen last cycle, the pending set,
   // the mask, whether a pulse is being sent / an ISR is running, last id.
   bit [NUM_IRQ-1:0] m_prev;
   bit [NUM_IRQ-1:0] m_pend;
   bit [NUM_IRQ-1:0] m_mask = '1;
   bit               m_pulse;
   bit               m_busy;
   int               m_id;

   task automatic cmp(input string nm, input logic [31:0] act, input int exp);
      n_vec++;
      if (act !== 32'(exp)) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_prev  = '0;
      m_pend  = '0;
      m_mask  = '1;
      m_pulse = 1'b0;
      m_busy  = 1'b0;
      m_id    = 0;
      exp_q.delete();
   endtask

   task automatic model_step();
      bit [NUM_IRQ-1:0] rise;
      bit [NUM_IRQ-1:0] elig;
      bit               ret;
      int               w;
      rise   = irq_in & ~m_prev;
      m_prev = irq_in;
      ret    = (ins[19:15] == 5'b10000);
      elig   = m_pend & ~m_mask;
      if (m_pulse) begin
         m_pulse = 1'b0;
         m_busy  = 1'b1;
      end else if (m_busy) begin
         if (ret) m_busy = 1'b0;
      end else if (elig != 0 && !pc_mux_sel && !ret) begin
         w = 0;
         while (!elig[w]) w++;
         m_pend[w] = 1'b0;
         m_id      = w;
         m_pulse   = 1'b1;
         exp_q.push_back('{cyc: cyc, id: w});
      end
      m_pend = m_pend | rise;
      if (mask_we) m_mask = mask_wdata;
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) begin
            model_reset();
         end else begin
            cyc++;
            model_step();
         end
      end
   end

   // Monitor: status outputs every cycle, pulses against the expected queue.
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en && reset) begin
            cmp("pending", 32'(pending), int'(m_pend));
            cmp("in_service", 32'(in_service), int'(m_busy));
            cmp("irq_mask", 32'(irq_mask), int'(m_mask));
            cmp("int_id", 32'(int_id), m_id);
            if (interrupt === 1'b1) begin
               if (exp_q.size() == 0) begin
                  n_vec++;
                  n_bad++;
                  $display("FAIL spurious_interrupt: got 1 expected 0 (cycle %0d)", cyc);
               end else begin
                  mon_e = exp_q.pop_front();
                  cmp("pulse_cycle", 32'(cyc), mon_e.cyc);
                  cmp("pulse_id", 32'(int_id), mon_e.id);
               end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
               mon_e = exp_q.pop_front();
               n_vec++;
               n_bad++;
               $display("FAIL missed_interrupt: got 0 expected pulse id %0d at cycle %0d (now %0d)",
                        mon_e.id, mon_e.cyc, cyc);
            end
         end
      end
   end

   task automatic drive(input logic [3:0] irq, input logic we, input logic [3:0] wd,
                        input logic [19:0] i_ins, input logic pcs);
      @(negedge clk);
      #1;
      irq_in     = irq;
      mask_we    = we;
      mask_wdata = wd;
      ins        = i_ins;
      pc_mux_sel = pcs;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) drive(irq_in, 1'b0, 4'h0, 20'h0, 1'b0);
   endtask

   task automatic check_reset_values(input string tag);
      cmp({tag, "_interrupt"}, 32'(interrupt), 0);
      cmp({tag, "_int_id"}, 32'(int_id), 0);
      cmp({tag, "_in_service"}, 32'(in_service), 0);
      cmp({tag, "_pending"}, 32'(pending), 0);
      cmp({tag, "_irq_mask"}, 32'(irq_mask), 15);
   endtask

   initial begin
      logic [3:0]  r_irq;
      logic [19:0] r_ins;
      #1 reset = 1'b0;
      #3 check_reset_values("rst");
      @(negedge clk);
      #1 reset = 1'b1;
      chk_en = 1'b1;

      // T1: single pulse on line 2 with mask cleared
      drive(4'h0, 1'b1, 4'h0, 20'h0, 1'b0);
      drive(4'b0100, 1'b0, 4'h0, 20'h0, 1'b0);
      drive(4'h0, 1'b0, 4'h0, 20'h0, 1'b0);
      @(negedge clk);
      cmp("t1_interrupt", 32'(interrupt), 1);
      cmp("t1_int_id", 32'(int_id), 2);
      cmp("t1_pending", 32'(pending), 0);
      @(negedge clk);
      cmp("t1_pulse_end", 32'(interrupt), 0);
      cmp("t1_in_service", 32'(in_service), 1);
      drive(4'h0, 1'b0, 4'h0, RET, 1'b0);
      idle(3);

      // T2: two lines rise together, lowest wins, other fires after RET
      drive(4'b1010, 1'b0, 4'h0, 20'h0, 1'b0);
      drive(4'h0, 1'b0, 4'h0, 20'h0, 1'b0);
      idle(4);
      cmp("t2_pending", 32'(pending), 8);
      cmp("t2_first_id", 32'(int_id), 1);
      drive(4'h0, 1'b0, 4'h0, RET, 1'b0);
      idle(4);
      cmp("t2_second_id", 32'(int_id), 3);
      drive(4'h0, 1'b0, 4'h0, RET, 1'b0);
      idle(2);

      // T3: masked request is retained, fires after unmasking
      drive(4'h0, 1'b1, 4'b0001, 20'h0, 1'b0);
      drive(4'b0001, 1'b0, 4'h0, 20'h0, 1'b0);
      drive(4'h0, 1'b0, 4'h0, 20'h0, 1'b0);
      idle(3);
      cmp("t3_masked_pending", 32'(pending), 1);
      cmp("t3_masked_idle", 32'(in_service), 0);
      drive(4'h0, 1'b1, 4'h0, 20'h0, 1'b0);
      idle(4);
      cmp("t3_unmasked_service", 32'(in_service), 1);
      drive(4'h0, 1'b0, 4'h0, RET, 1'b0);
      idle(2);

      // T4: control transfer defers the request for 3 cycles
      drive(4'b0100, 1'b0, 4'h0, 20'h0, 1'b1);
      drive(4'h0, 1'b0, 4'h0, 20'h0, 1'b1);
      drive(4'h0, 1'b0, 4'h0, 20'h0, 1'b1);
      idle(4);
      drive(4'h0, 1'b0, 4'h0, RET, 1'b0);
      idle(2);

      // T5: held level raises one request; re-rise in the ack cycle survives
      drive(4'b0010, 1'b0, 4'h0, 20'h0, 1'b0);
      idle(20);
      drive(4'h0, 1'b0, 4'h0, 20'h0, 1'b0);
      drive(4'b0010, 1'b0, 4'h0, 20'h0, 1'b0);
      drive(4'h0, 1'b0, 4'h0, 20'h0, 1'b0);
      drive(4'h0, 1'b0, 4'h0, RET, 1'b0);
      drive(4'b0010, 1'b0, 4'h0, 20'h0, 1'b0);
      @(negedge clk);
      cmp("t5_ack_interrupt", 32'(interrupt), 1);
      cmp("t5_set_wins", 32'(pending[1]), 1);
      idle(3);
      drive(4'h0, 1'b0, 4'h0, RET, 1'b0);
      idle(4);
      drive(4'h0, 1'b0, 4'h0, RET, 1'b0);
      idle(2);

      // T6: asynchronous reset while servicing with a request pending
      drive(4'b0001, 1'b0, 4'h0, 20'h0, 1'b0);
      drive(4'h0, 1'b0, 4'h0, 20'h0, 1'b0);
      idle(3);
      drive(4'b0100, 1'b0, 4'h0, 20'h0, 1'b0);
      drive(4'h0, 1'b0, 4'h0, 20'h0, 1'b0);
      idle(2);
      cmp("t6_pre_pending", 32'(pending), 4);
      cmp("t6_pre_service", 32'(in_service), 1);
      @(negedge clk);
      #3 reset = 1'b0;
      #1 check_reset_values("t6");
      @(negedge clk);
      #1 reset = 1'b1;
      drive(4'h0, 1'b1, 4'h0, 20'h0, 1'b0);
      idle(6);
      cmp("t6_no_refire", 32'(in_service), 0);

      // Randomised traffic
      for (int n = 0; n < 1500; n++) begin
         r_irq = irq_in;
         for (int b = 0; b < NUM_IRQ; b++)
            if ($urandom_range(0, 7) == 0) r_irq[b] = ~r_irq[b];
         r_ins = 20'($urandom());
         if ($urandom_range(0, 5) == 0) r_ins[19:15] = 5'b10000;
         drive(r_irq, ($urandom_range(0, 15) == 0), 4'($urandom()), r_ins,
               ($urandom_range(0, 3) == 0));
      end
      idle(5);

      n_vec++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL leftover_expected: got %0d outstanding expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
